// File: rtl/restoring_divider_ctrl.sv
// Sequential unsigned restoring divider: one shift plus one ripple-borrow trial subtraction per clock.
// Optional build macro DIVZERO_ERR_EN: divide-by-zero short-circuits to DONE and raises err.
module restoring_divider_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             err
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH:0]   rem_reg;
   logic [WIDTH-1:0] quo_reg;
   logic [WIDTH-1:0] div_reg;
   logic [CW-1:0]    cnt_reg;

   // Shifted partial remainder and the WIDTH+1-bit ripple-borrow trial subtraction.
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   sub_b;
   logic [WIDTH:0]   trial;
   logic [WIDTH+1:0] borrow;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] quo_next;

   assign shifted   = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
   assign sub_b     = {1'b0, div_reg};
   assign borrow[0] = 1'b0;

   generate
      for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_borrow
         assign trial[gi]      = shifted[gi] ^ sub_b[gi] ^ borrow[gi];
         assign borrow[gi + 1] = (~shifted[gi] & sub_b[gi]) |
                                 (~(shifted[gi] ^ sub_b[gi]) & borrow[gi]);
      end
   endgenerate

   assign rem_next = borrow[WIDTH+1] ? shifted : trial;
   assign quo_next = {quo_reg[WIDTH-2:0], ~borrow[WIDTH+1]};

`ifdef DIVZERO_ERR_EN
   logic divz_reg;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         q       <= '0;
         r       <= '0;
         rem_reg <= '0;
         quo_reg <= '0;
         div_reg <= '0;
         cnt_reg <= '0;
`ifdef DIVZERO_ERR_EN
         err      <= 1'b0;
         divz_reg <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  rem_reg <= '0;
                  quo_reg <= dividend;
                  div_reg <= divisor;
                  cnt_reg <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
`ifdef DIVZERO_ERR_EN
                  divz_reg <= (divisor == '0);
                  if (divisor != '0) err <= 1'b0;
`endif
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
`ifdef DIVZERO_ERR_EN
               // Zero divisor: dividend is still untouched in quo_reg, report it directly.
               if (divz_reg) begin
                  q        <= '1;
                  r        <= quo_reg;
                  err      <= 1'b1;
                  divz_reg <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else
`endif
               begin
                  rem_reg <= rem_next;
                  quo_reg <= quo_next;
                  cnt_reg <= cnt_reg + 1'b1;
                  if (cnt_reg == LAST_STEP) begin
                     q     <= quo_next;
                     r     <= rem_next[WIDTH-1:0];
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_restoring_divider_ctrl.sv
// Self-checking bench for restoring_divider_ctrl: directed scenarios plus randomized and exhaustive
// operands compared against plain integer division.
module tb_restoring_divider_ctrl;

   localparam int WIDTH = 4;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] dividend, divisor, q, r;
   logic             busy, done, err;

   int vectors     = 0;
   int miscompares = 0;
   int last_q, last_r;

   restoring_divider_ctrl #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .q(q), .r(r), .err(err)
   );

   always #5 clk = ~clk;

   task automatic model(input int a, input int b, output int eq, output int er,
                        output int ee, output int elat);
      if (b == 0) begin
         eq = MAXV;
         er = a;
`ifdef DIVZERO_ERR_EN
         ee = 1; elat = 1;
`else
         ee = 0; elat = WIDTH;
`endif
      end else begin
         eq = a / b; er = a % b; ee = 0; elat = WIDTH;
      end
   endtask

   // Called right after the accepting edge (+1): follows busy until done, checks everything.
   task automatic wait_result(input int a, input int b, input string name);
      int eq, er, ee, elat, lat, busy_cnt;
      bit got;
      model(a, b, eq, er, ee, elat);
      lat = 0; busy_cnt = 0; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (busy === 1'b1) busy_cnt++;
         @(posedge clk); #1;
         lat++;
         if (done === 1'b1) got = 1;
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL %s timeout: no done after %0d cycles (required %0d)", name, lat, elat);
      end else begin
         vectors += 5;
         if (lat != elat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, elat);
         end
         if (busy_cnt != elat || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy: high %0d cycles, at done %b; required %0d, 0", name, busy_cnt, busy, elat);
         end
         if (q !== WIDTH'(eq)) begin
            miscompares++;
            $display("FAIL %s q: %0d/%0d got %0d required %0d", name, a, b, q, eq);
         end
         if (r !== WIDTH'(er)) begin
            miscompares++;
            $display("FAIL %s r: %0d/%0d got %0d required %0d", name, a, b, r, er);
         end
         if (err !== 1'(ee)) begin
            miscompares++;
            $display("FAIL %s err: got %b required %0d", name, err, ee);
         end
      end
      last_q = int'(q);
      last_r = int'(r);
      $display("%s: %0d / %0d -> q=%0d r=%0d err=%b latency=%0d", name, a, b, q, r, err, lat);
   endtask

   task automatic run_div(input int a, input int b, input string name);
      dividend = WIDTH'(a); divisor = WIDTH'(b); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_result(a, b, name);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({busy, done, q, r, err} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: busy=%b done=%b q=%0d r=%0d err=%b required all 0", busy, done, q, r, err);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      $display("reset: outputs cleared");
   endtask

   task automatic test_basic();
      run_div(13, 3, "basic");
   endtask

   task automatic test_back_to_back();
      run_div(15, 1, "b2b_first");
      // Still inside the DONE cycle: present the next operands with start high.
      dividend = WIDTH'(5); divisor = WIDTH'(7); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_accept: busy=%b done=%b required 1,0", busy, done);
      end
      wait_result(5, 7, "b2b_second");
   endtask

   task automatic test_ignore_start();
      int done_cnt, lat, seen_q, seen_r, done_lat;
      dividend = WIDTH'(12); divisor = WIDTH'(5); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      done_cnt = 0; seen_q = -1; seen_r = -1; done_lat = 0;
      for (lat = 1; lat <= 10; lat++) begin
         if (lat == 2) begin
            dividend = WIDTH'(9); divisor = WIDTH'(2); start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done === 1'b1) begin
            done_cnt++; seen_q = int'(q); seen_r = int'(r); done_lat = lat;
         end
      end
      start = 1'b0;
      vectors += 3;
      if (done_cnt != 1) begin
         miscompares++;
         $display("FAIL ignore_pulses: got %0d done pulses required 1", done_cnt);
      end
      if (done_lat != WIDTH) begin
         miscompares++;
         $display("FAIL ignore_latency: got %0d required %0d", done_lat, WIDTH);
      end
      if (seen_q != 2 || seen_r != 2) begin
         miscompares++;
         $display("FAIL ignore_result: got q=%0d r=%0d required q=2 r=2", seen_q, seen_r);
      end
      $display("ignore_start: 12/5 with mid-run 9/2 start -> q=%0d r=%0d pulses=%0d", seen_q, seen_r, done_cnt);
   endtask

   task automatic test_async_reset();
      int done_cnt;
      run_div(7, 2, "pre_reset");
      dividend = WIDTH'(14); divisor = WIDTH'(3); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      vectors++;
      if ({busy, done, q, r, err} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: busy=%b done=%b q=%0d r=%0d err=%b required all 0", busy, done, q, r, err);
      end
      #2 rst = 1'b0;
      done_cnt = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) done_cnt++;
      end
      vectors++;
      if (done_cnt != 0) begin
         miscompares++;
         $display("FAIL async_reset_quiet: %0d cycles with busy/done after reset, required 0", done_cnt);
      end
      $display("async_reset: mid-run reset discarded partial result");
      run_div(14, 3, "post_reset");
   endtask

   task automatic test_divzero();
      run_div(6, 0, "divzero");
      run_div(8, 4, "after_divzero");
   endtask

   task automatic test_random();
      int a, b, gap;
      for (int i = 0; i < 60; i++) begin
         a = int'($urandom_range(MAXV, 0));
         b = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(MAXV, 0));
         gap = int'($urandom_range(2, 0));
         repeat (gap) begin
            @(posedge clk); #1;
         end
         run_div(a, b, "random");
      end
   endtask

   task automatic test_sweep();
      for (int a = 0; a <= MAXV; a++) begin
         for (int b = 0; b <= MAXV; b++) begin
            run_div(a, b, "sweep");
            if (b != 0) begin
               vectors++;
               if (last_q * b + last_r != a || last_r >= b) begin
                  miscompares++;
                  $display("FAIL sweep_identity: %0d/%0d gave q=%0d r=%0d", a, b, last_q, last_r);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_ignore_start();
      test_async_reset();
      test_divzero();
      test_random();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
